// File: rtl/branch_predictor_pkg.sv
// Shared types and constants for the branch predictor: BTB entry layout,
// 2-bit counter encodings and the sequential-fetch PC increment.
package bp_pkg;

    // These set the entry layout; keep PC_W/ENTRIES on branch_predictor equal to them.
    localparam int BP_PC_W    = 9;
    localparam int BP_ENTRIES = 16;
    localparam int BP_IDX_W   = $clog2(BP_ENTRIES);
    localparam int BP_TAG_W   = BP_PC_W - 2 - BP_IDX_W;

    localparam logic [1:0] BP_SNT = 2'b00;
    localparam logic [1:0] BP_WNT = 2'b01;
    localparam logic [1:0] BP_WT  = 2'b10;
    localparam logic [1:0] BP_ST  = 2'b11;

    localparam int unsigned BP_PC_INC = 4;

    typedef struct packed {
        logic                valid;
        logic [BP_TAG_W-1:0] tag;
        logic [BP_PC_W-1:0]  target;
        logic [1:0]          cnt;
    } bp_entry_t;

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch-lookup and EX-resolve signals between the pipeline (master) and the
// branch predictor (slave).
interface branch_predictor_if #(
    parameter int PC_W  = 9,
    parameter int CNT_W = 16
);
    logic [PC_W-1:0]  if_pc;
    logic             pred_taken;
    logic [PC_W-1:0]  pred_target;

    logic             ex_valid;
    logic [PC_W-1:0]  ex_pc;
    logic             ex_is_jump;
    logic             ex_taken;
    logic [PC_W-1:0]  ex_target;
    logic             ex_pred_taken;
    logic [PC_W-1:0]  ex_pred_target;

    logic             mispredict;
    logic [PC_W-1:0]  redirect_pc;
    logic [CNT_W-1:0] br_count;
    logic [CNT_W-1:0] miss_count;

    modport master (
        output if_pc, ex_valid, ex_pc, ex_is_jump, ex_taken, ex_target,
               ex_pred_taken, ex_pred_target,
        input  pred_taken, pred_target, mispredict, redirect_pc,
               br_count, miss_count
    );

    modport slave (
        input  if_pc, ex_valid, ex_pc, ex_is_jump, ex_taken, ex_target,
               ex_pred_taken, ex_pred_target,
        output pred_taken, pred_target, mispredict, redirect_pc,
               br_count, miss_count
    );
endinterface

// File: rtl/branch_predictor_sat_counter.sv
// Next-state logic for one 2-bit saturating direction counter; a jump forces
// strong-taken.
module bp_sat_counter
    import bp_pkg::*;
(
    input  logic [1:0] cnt,
    input  logic       taken,
    input  logic       force_st,
    output logic [1:0] cnt_next
);

    // NOTE: default assignment first so every path drives cnt_next and no latch is inferred.
    always_comb begin
        cnt_next = cnt;
        if (force_st) begin
            cnt_next = BP_ST;
        end else if (taken) begin
            if (cnt != BP_ST) cnt_next = cnt + 2'd1;
        end else begin
            if (cnt != BP_SNT) cnt_next = cnt - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters: combinational IF lookup, EX training,
// mispredict/redirect and perf counters. Define BP_GSHARE_EN for gshare indexing.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int PC_W    = BP_PC_W,
    parameter int ENTRIES = BP_ENTRIES,
    parameter int GHR_W   = 4,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    branch_predictor_if.slave bus
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = PC_W - 2 - IDX_W;
    localparam logic [PC_W-1:0] PC_INC = PC_W'(BP_PC_INC);

    bp_entry_t        table_q  [ENTRIES];
    logic [1:0]       cnt_next [ENTRIES];
    logic [IDX_W-1:0] hist;

`ifdef BP_GSHARE_EN
    logic [GHR_W-1:0] ghr_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            ghr_q <= '0;
        end else if (bus.ex_valid && !bus.ex_is_jump) begin
            ghr_q <= GHR_W'({ghr_q, bus.ex_taken});
        end
    end

    // Update uses ghr_q as registered, i.e. the history before this cycle's shift.
    assign hist = IDX_W'(ghr_q);
`else
    assign hist = '0;
`endif

    // Lookup: table read is combinational and sees only committed state.
    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    bp_entry_t        lk_entry;
    logic             lk_hit;

    assign lk_idx   = bus.if_pc[IDX_W+1:2] ^ hist;
    assign lk_tag   = bus.if_pc[PC_W-1:IDX_W+2];
    assign lk_entry = table_q[lk_idx];
    assign lk_hit   = lk_entry.valid && (lk_entry.tag == lk_tag);

    assign bus.pred_taken  = lk_hit && lk_entry.cnt[1];
    assign bus.pred_target = bus.pred_taken ? lk_entry.target : bus.if_pc + PC_INC;

    // Resolution in EX.
    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag;
    logic             upd_hit;

    assign upd_idx = bus.ex_pc[IDX_W+1:2] ^ hist;
    assign upd_tag = bus.ex_pc[PC_W-1:IDX_W+2];
    assign upd_hit = table_q[upd_idx].valid && (table_q[upd_idx].tag == upd_tag);

    assign bus.mispredict = bus.ex_valid &&
                            ((bus.ex_taken != bus.ex_pred_taken) ||
                             (bus.ex_taken && (bus.ex_target != bus.ex_pred_target)));
    assign bus.redirect_pc = bus.ex_taken ? bus.ex_target : bus.ex_pc + PC_INC;

    for (genvar g = 0; g < ENTRIES; g++) begin : g_cnt
        bp_sat_counter u_cnt (
            .cnt      (table_q[g].cnt),
            .taken    (bus.ex_taken),
            .force_st (bus.ex_is_jump),
            .cnt_next (cnt_next[g])
        );
    end

    // NOTE: only valid and cnt are reset; tag/target are don't-care while valid=0,
    // so leaving them unreset keeps the table as plain enable flops.
    always_ff @(posedge clk) begin
        for (int i = 0; i < ENTRIES; i++) begin
            if (reset) begin
                table_q[i].valid <= 1'b0;
                table_q[i].cnt   <= BP_SNT;
            end else if (bus.ex_valid && (upd_idx == IDX_W'(i))) begin
                if (upd_hit) begin
                    table_q[i].cnt <= cnt_next[i];
                    if (bus.ex_taken) table_q[i].target <= bus.ex_target;
                end else if (bus.ex_taken) begin
                    table_q[i].valid  <= 1'b1;
                    table_q[i].tag    <= upd_tag;
                    table_q[i].target <= bus.ex_target;
                    table_q[i].cnt    <= bus.ex_is_jump ? BP_ST : BP_WT;
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.br_count   <= '0;
            bus.miss_count <= '0;
        end else begin
            if (bus.ex_valid && (bus.br_count != '1))
                bus.br_count <= bus.br_count + 1'b1;
            if (bus.mispredict && (bus.miss_count != '1))
                bus.miss_count <= bus.miss_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed test of branch_predictor (default bimodal build, CNT_W=4) with
// hand-computed expectations.
module tb_branch_predictor;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    branch_predictor_if #(.PC_W(9), .CNT_W(4)) bus ();

    branch_predictor #(.PC_W(9), .ENTRIES(16), .GHR_W(4), .CNT_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic resolve(input logic [8:0] pc, input logic jump, input logic taken,
                           input logic [8:0] tgt, input logic pt, input logic [8:0] ptgt);
        bus.ex_valid       = 1'b1;
        bus.ex_pc          = pc;
        bus.ex_is_jump     = jump;
        bus.ex_taken       = taken;
        bus.ex_target      = tgt;
        bus.ex_pred_taken  = pt;
        bus.ex_pred_target = ptgt;
        #1;
    endtask

    task automatic idle();
        bus.ex_valid = 1'b0;
        #1;
    endtask

    task automatic lookup(input string tag, input logic [8:0] pc,
                          input logic exp_taken, input logic [8:0] exp_tgt);
        bus.if_pc = pc;
        #1;
        check({tag, "_taken"},  32'(bus.pred_taken),  32'(exp_taken));
        check({tag, "_target"}, 32'(bus.pred_target), 32'(exp_tgt));
    endtask

    task automatic counts(input string tag, input int br, input int miss);
        check({tag, "_br"},   32'(bus.br_count),   32'(br));
        check({tag, "_miss"}, 32'(bus.miss_count), 32'(miss));
    endtask

    initial begin
        reset = 1'b1;
        bus.if_pc = 9'h010;
        bus.ex_valid = 1'b0;
        bus.ex_pc = '0;
        bus.ex_is_jump = 1'b0;
        bus.ex_taken = 1'b0;
        bus.ex_target = '0;
        bus.ex_pred_taken = 1'b0;
        bus.ex_pred_target = '0;
        tick();
        tick();
        reset = 1'b0;
        #1;
        lookup("reset", 9'h010, 1'b0, 9'h014);
        counts("reset", 0, 0);

        // First taken resolve allocates with cnt=10; same-cycle lookup sees old table.
        resolve(9'h020, 1'b0, 1'b1, 9'h040, 1'b0, 9'h024);
        check("alloc_mispredict", 32'(bus.mispredict), 32'd1);
        check("alloc_redirect", 32'(bus.redirect_pc), 32'h040);
        lookup("alloc_same_cycle", 9'h020, 1'b0, 9'h024);
        tick();
        idle();
        lookup("alloc_next", 9'h020, 1'b1, 9'h040);
        counts("alloc", 1, 1);

        // Not taken twice: 10 -> 01 -> 00.
        resolve(9'h020, 1'b0, 1'b0, 9'h040, 1'b1, 9'h040);
        check("nt1_mispredict", 32'(bus.mispredict), 32'd1);
        check("nt1_redirect", 32'(bus.redirect_pc), 32'h024);
        tick();
        idle();
        lookup("nt1", 9'h020, 1'b0, 9'h024);
        resolve(9'h020, 1'b0, 1'b0, 9'h040, 1'b0, 9'h024);
        check("nt2_mispredict", 32'(bus.mispredict), 32'd0);
        tick();
        // From 00, a taken update only reaches 01.
        resolve(9'h020, 1'b0, 1'b1, 9'h040, 1'b0, 9'h024);
        tick();
        idle();
        lookup("sat_low", 9'h020, 1'b0, 9'h024);
        resolve(9'h020, 1'b0, 1'b1, 9'h040, 1'b0, 9'h024);
        tick();
        idle();
        lookup("retrain", 9'h020, 1'b1, 9'h040);
        counts("retrain", 5, 4);

        // Same index, different tag misses.
        lookup("alias", 9'h060, 1'b0, 9'h064);

        // Saturate high: 10 -> 11 -> 11 -> 10 -> 01.
        resolve(9'h020, 1'b0, 1'b1, 9'h040, 1'b1, 9'h040);
        check("correct_mispredict", 32'(bus.mispredict), 32'd0);
        tick();
        resolve(9'h020, 1'b0, 1'b1, 9'h040, 1'b1, 9'h040);
        tick();
        resolve(9'h020, 1'b0, 1'b0, 9'h040, 1'b1, 9'h040);
        tick();
        resolve(9'h020, 1'b0, 1'b0, 9'h040, 1'b1, 9'h040);
        tick();
        idle();
        lookup("sat_high", 9'h020, 1'b0, 9'h024);
        counts("sat_high", 9, 6);

        // Jump allocates strong-taken; a new target on a hit is a target mispredict.
        resolve(9'h030, 1'b1, 1'b1, 9'h100, 1'b0, 9'h034);
        tick();
        idle();
        lookup("jump_alloc", 9'h030, 1'b1, 9'h100);
        resolve(9'h030, 1'b1, 1'b1, 9'h180, 1'b1, 9'h100);
        check("jump_tgt_mispredict", 32'(bus.mispredict), 32'd1);
        check("jump_tgt_redirect", 32'(bus.redirect_pc), 32'h180);
        tick();
        idle();
        lookup("jump_retarget", 9'h030, 1'b1, 9'h180);
        counts("jump", 11, 8);

        // Miss and not taken leaves the table alone.
        resolve(9'h0A0, 1'b0, 1'b0, 9'h000, 1'b0, 9'h0A4);
        check("miss_nt_mispredict", 32'(bus.mispredict), 32'd0);
        tick();
        idle();
        lookup("miss_nt", 9'h0A0, 1'b0, 9'h0A4);

        // PC+4 wraps.
        resolve(9'h1FC, 1'b0, 1'b0, 9'h000, 1'b1, 9'h010);
        check("wrap_mispredict", 32'(bus.mispredict), 32'd1);
        check("wrap_redirect", 32'(bus.redirect_pc), 32'h000);
        tick();
        idle();
        lookup("wrap", 9'h1FC, 1'b0, 9'h000);

        // Hit update 01 -> 10 with new target; lookup shows pre-update contents.
        resolve(9'h020, 1'b0, 1'b1, 9'h044, 1'b0, 9'h024);
        lookup("same_cycle_old", 9'h020, 1'b0, 9'h024);
        tick();
        idle();
        lookup("same_cycle_new", 9'h020, 1'b1, 9'h044);
        counts("same_cycle", 14, 10);

        // Perf counters saturate at all-ones.
        for (int i = 0; i < 20; i++) begin
            resolve(9'h0C0, 1'b0, 1'b0, 9'h000, 1'b1, 9'h010);
            tick();
        end
        idle();
        counts("perf_sat", 15, 15);

        // Reset wins over a same-cycle allocating update.
        reset = 1'b1;
        resolve(9'h100, 1'b0, 1'b1, 9'h010, 1'b0, 9'h104);
        check("reset_mispredict", 32'(bus.mispredict), 32'd1);
        tick();
        reset = 1'b0;
        idle();
        lookup("reset_upd", 9'h100, 1'b0, 9'h104);
        lookup("reset_clear", 9'h020, 1'b0, 9'h024);
        counts("reset2", 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
